cfg_chain_loader: RTL and testbench

//  Host-side driver for the serial configuration scan chain of a CLB/tile column.

---
 rtl/cfg_chain_loader.sv | 256 +++++++++++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: takes bitstream words over valid/ready and shifts them LSB-first into a config scan chain.
// Define CFG_LOADER_CRC_EN to require a trailing CRC-8 word that is checked after the last shift.
module cfg_chain_loader #(
    parameter int CHAIN_LEN = 37,
    parameter int WORD_W    = 8
) (
    input  logic              cfg_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_last,
    output logic              cfg_out,
    output logic              cfg_en,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
`ifdef CFG_LOADER_CRC_EN
    localparam int LAST_IDX = NWORDS;
`else
    localparam int LAST_IDX = NWORDS - 1;
`endif
    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int SW = $clog2(WORD_W + 1);
    localparam int IW = $clog2(LAST_IDX + 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
`ifdef CFG_LOADER_CRC_EN
        , ST_CHECK = 2'd3
`endif
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [BW-1:0]     bit_cnt_reg;
    logic [IW-1:0]     word_idx_reg;
    logic [WORD_W-1:0] shift_reg;
    logic [SW-1:0]     shift_left_reg;
    logic [WORD_W-1:0] hold_reg;
    logic              hold_full_reg;
    logic              len_err_reg;
    logic              done_reg;
    logic              error_reg;
    logic              set_done;
    logic              set_error;

    logic start_ok;
    logic accept;
    logic accept_data;
    logic in_shift_state;
    logic chain_full;
    logic shift_active;
    logic shift_ends;
    logic shifter_free;
    logic is_last_idx;
    logic final_shift;
    logic pending;
    logic len_err_now;

    assign start_ok       = (state_reg == ST_IDLE) && start;
    assign accept         = word_valid && word_ready;
    assign in_shift_state = (state_reg == ST_LOAD) || (state_reg == ST_DRAIN);
    assign chain_full     = (bit_cnt_reg == BW'(CHAIN_LEN));
    // Once the chain holds CHAIN_LEN bits, any leftover pad bits in the shifter are never driven out.
    assign shift_active   = in_shift_state && (shift_left_reg != '0) && !chain_full;
    assign shift_ends     = shift_active && (shift_left_reg == SW'(1));
    assign shifter_free   = (shift_left_reg == '0) || shift_ends;
    assign is_last_idx    = (word_idx_reg == IW'(LAST_IDX));
    assign final_shift    = shift_active && (bit_cnt_reg == BW'(CHAIN_LEN - 1));
    assign pending        = (shift_left_reg != '0) || hold_full_reg;
    // word_last early is a short stream; no word_last on the final index is a long stream.
    assign len_err_now    = accept && (word_last != is_last_idx);

`ifdef CFG_LOADER_CRC_EN
    logic       is_crc_word;
    logic [7:0] crc_reg;
    logic [7:0] crc_exp_reg;
    logic [7:0] crc_word;

    assign is_crc_word = accept && (word_idx_reg == IW'(NWORDS));
    assign accept_data = accept && !is_crc_word;

    generate
        if (WORD_W >= 8) begin : g_crc_wide
            assign crc_word = word_data[7:0];
        end else begin : g_crc_narrow
            assign crc_word = {{(8 - WORD_W){1'b0}}, word_data};
        end
    endgenerate

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic [7:0] shifted;
        shifted = {crc[6:0], 1'b0};
        return (crc[7] ^ din) ? (shifted ^ 8'h07) : shifted;
    endfunction

    always_ff @(posedge cfg_clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_reg     <= '0;
            crc_exp_reg <= '0;
        end else if (start_ok) begin
            crc_reg     <= '0;
            crc_exp_reg <= '0;
        end else begin
            if (shift_active) begin
                crc_reg <= crc8_step(crc_reg, shift_reg[0]);
            end
            if (is_crc_word) begin
                crc_exp_reg <= crc_word;
            end
        end
    end
`else
    assign accept_data = accept;
`endif

    always_ff @(posedge cfg_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        set_done   = 1'b0;
        set_error  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept && (word_last || is_last_idx)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (final_shift || chain_full) begin
                    if (len_err_reg) begin
                        state_next = ST_IDLE;
                        set_error  = 1'b1;
                    end else begin
`ifdef CFG_LOADER_CRC_EN
                        state_next = ST_CHECK;
`else
                        state_next = ST_IDLE;
                        set_done   = 1'b1;
`endif
                    end
                end else if (!pending) begin
                    state_next = ST_IDLE;
                    set_error  = 1'b1;
                end
            end
`ifdef CFG_LOADER_CRC_EN
            ST_CHECK: begin
                state_next = ST_IDLE;
                if (crc_reg == crc_exp_reg) begin
                    set_done  = 1'b1;
                end else begin
                    set_error = 1'b1;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        word_ready = (state_reg == ST_LOAD) && !hold_full_reg;
        cfg_en     = shift_active;
        cfg_out    = shift_active & shift_reg[0];
        busy       = (state_reg != ST_IDLE);
        done       = done_reg;
        error      = error_reg;
    end

    // Shifter plus one holding word: the hold slot refills the shifter on its last bit, so
    // back-to-back host words shift without a gap.
    always_ff @(posedge cfg_clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg      <= '0;
            shift_left_reg <= '0;
            hold_reg       <= '0;
            hold_full_reg  <= 1'b0;
        end else if ((state_reg == ST_IDLE) || (state_next == ST_IDLE)) begin
            shift_reg      <= '0;
            shift_left_reg <= '0;
            hold_reg       <= '0;
            hold_full_reg  <= 1'b0;
        end else if (shifter_free) begin
            if (hold_full_reg) begin
                shift_reg      <= hold_reg;
                shift_left_reg <= SW'(WORD_W);
                hold_full_reg  <= 1'b0;
            end else if (accept_data) begin
                shift_reg      <= word_data;
                shift_left_reg <= SW'(WORD_W);
            end else begin
                shift_left_reg <= '0;
            end
        end else begin
            if (shift_active) begin
                shift_reg      <= shift_reg >> 1;
                shift_left_reg <= shift_left_reg - SW'(1);
            end
            if (accept_data) begin
                hold_reg      <= word_data;
                hold_full_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge cfg_clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_reg  <= '0;
            word_idx_reg <= '0;
            len_err_reg  <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            done_reg <= set_done;
            if (start_ok) begin
                bit_cnt_reg  <= '0;
                word_idx_reg <= '0;
                len_err_reg  <= 1'b0;
                error_reg    <= 1'b0;
            end else begin
                if (shift_active) begin
                    bit_cnt_reg <= bit_cnt_reg + BW'(1);
                end
                if (accept) begin
                    word_idx_reg <= word_idx_reg + IW'(1);
                end
                if (len_err_now) begin
                    len_err_reg <= 1'b1;
                end
                if (set_error) begin
                    error_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed testbench for cfg_chain_loader (CHAIN_LEN=37, WORD_W=8); CRC steps are included when CFG_LOADER_CRC_EN is defined.
module tb_cfg_chain_loader;
    localparam int CHAIN_LEN = 37;
    localparam int WORD_W    = 8;
`ifdef CFG_LOADER_CRC_EN
    localparam int NSEND = 6;
`else
    localparam int NSEND = 5;
`endif
    localparam logic [63:0] EXP_FULL  = 64'h15_00FF_3CA5;
    localparam logic [63:0] EXP_SHORT = 64'hFF_3CA5;

    logic       cfg_clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       word_valid;
    logic       word_ready;
    logic [7:0] word_data;
    logic       word_last;
    logic       cfg_out;
    logic       cfg_en;
    logic       busy;
    logic       done;
    logic       error;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          n_shift = 0;
    int          n_done = 0;
    int          out_viol = 0;
    int          first_cyc = -1;
    int          last_cyc = -1;
    logic [63:0] chain = '0;
    logic        mon_clr = 1'b0;
    int          n_acc = 0;
    int          first_acc_cyc = -2;
    logic [7:0]  extra5;
    logic [7:0]  crc_good;

    cfg_chain_loader #(
        .CHAIN_LEN(CHAIN_LEN),
        .WORD_W   (WORD_W)
    ) dut (
        .cfg_clk   (cfg_clk),
        .reset_n   (reset_n),
        .start     (start),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .word_data (word_data),
        .word_last (word_last),
        .cfg_out   (cfg_out),
        .cfg_en    (cfg_en),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 cfg_clk = ~cfg_clk;

    always @(posedge cfg_clk) cyc <= cyc + 1;

    // Records what actually reaches the chain head, sampled mid-cycle.
    always @(negedge cfg_clk) begin
        if (mon_clr) begin
            n_shift   = 0;
            n_done    = 0;
            out_viol  = 0;
            first_cyc = -1;
            last_cyc  = -1;
            chain     = '0;
        end else begin
            if (cfg_en) begin
                if (n_shift < 64) chain[n_shift] = cfg_out;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                n_shift++;
            end else if (cfg_out) begin
                out_viol++;
            end
            if (done) n_done++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] crc8_ref(input logic [63:0] bits, input int n);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            fb = c[7] ^ bits[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    function automatic logic [7:0] word_val(input int idx);
        case (idx)
            0: return 8'hA5;
            1: return 8'h3C;
            2: return 8'hFF;
            3: return 8'h00;
            4: return 8'h15;
            5: return extra5;
            default: return 8'h77;
        endcase
    endfunction

    task automatic tick();
        @(negedge cfg_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_load();
        start   = 1'b1;
        mon_clr = 1'b1;
        tick();
        start   = 1'b0;
        mon_clr = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input logic last, input int budget, output bit ok);
        int n;
        n          = 0;
        ok         = 1'b0;
        word_valid = 1'b1;
        word_data  = d;
        word_last  = last;
        while (!ok && n < budget) begin
            if (word_ready) ok = 1'b1;
            tick();
            n++;
        end
        word_valid = 1'b0;
        word_last  = 1'b0;
    endtask

    task automatic send_stream(input int nsend, input int last_idx, input bit stall);
        bit ok;
        int w;
        n_acc = 0;
        for (int i = 0; i < nsend; i++) begin
            if (stall && i == 2) begin
                w = 0;
                while (cfg_en && w < 100) begin
                    tick();
                    w++;
                end
                repeat (2) tick();
            end
            send_word(word_val(i), (i == last_idx), 60, ok);
            if (ok) begin
                n_acc++;
                if (i == 0) first_acc_cyc = cyc;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        while (busy && w < 300) begin
            tick();
            w++;
        end
        check(tag, 64'(busy), 64'd0);
        repeat (2) tick();
    endtask

    initial begin
        int w;
        reset_n    = 1'b0;
        start      = 1'b0;
        word_valid = 1'b0;
        word_last  = 1'b0;
        word_data  = 8'h00;
        crc_good   = crc8_ref(EXP_FULL, CHAIN_LEN);
`ifdef CFG_LOADER_CRC_EN
        extra5 = crc_good;
`else
        extra5 = 8'h77;
`endif
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        check("rst_word_ready", 64'(word_ready), 64'd0);
        check("rst_cfg_en",     64'(cfg_en),     64'd0);
        check("rst_cfg_out",    64'(cfg_out),    64'd0);
        check("rst_busy",       64'(busy),       64'd0);
        check("rst_done",       64'(done),       64'd0);
        check("rst_error",      64'(error),      64'd0);

        // 1: nominal back-to-back stream
        start_load();
        check("t1_busy_after_start", 64'(busy), 64'd1);
        send_stream(NSEND, NSEND - 1, 1'b0);
        wait_idle("t1_idle");
        check("t1_shifts",     64'(n_shift), 64'd37);
        check("t1_gaps",       64'(last_cyc - first_cyc + 1 - n_shift), 64'd0);
        check("t1_chain",      chain, EXP_FULL);
        check("t1_done_count", 64'(n_done), 64'd1);
        check("t1_error",      64'(error), 64'd0);
        check("t1_latency",    64'(first_cyc), 64'(first_acc_cyc));
        check("t1_ready_after", 64'(word_ready), 64'd0);
        check("t1_out_when_off", 64'(out_viol), 64'd0);
        check("t1_accepted",   64'(n_acc), 64'(NSEND));

        // 2: host stall before word 2
        start_load();
        send_stream(NSEND, NSEND - 1, 1'b1);
        wait_idle("t2_idle");
        check("t2_shifts",     64'(n_shift), 64'd37);
        check("t2_gaps",       64'(last_cyc - first_cyc + 1 - n_shift), 64'd3);
        check("t2_chain",      chain, EXP_FULL);
        check("t2_done_count", 64'(n_done), 64'd1);
        check("t2_error",      64'(error), 64'd0);

        // 3: short stream, last on word 2
        start_load();
        send_stream(3, 2, 1'b0);
        wait_idle("t3_idle");
        check("t3_shifts",     64'(n_shift), 64'd24);
        check("t3_chain",      chain, EXP_SHORT);
        check("t3_error",      64'(error), 64'd1);
        check("t3_done_count", 64'(n_done), 64'd0);
        check("t3_ready_after", 64'(word_ready), 64'd0);

        // 4: long stream, final word without last, one extra word offered
        start_load();
        check("t4_error_cleared", 64'(error), 64'd0);
        send_stream(NSEND + 1, -1, 1'b0);
        wait_idle("t4_idle");
        check("t4_shifts",     64'(n_shift), 64'd37);
        check("t4_chain",      chain, EXP_FULL);
        check("t4_error",      64'(error), 64'd1);
        check("t4_done_count", 64'(n_done), 64'd0);
        check("t4_accepted",   64'(n_acc), 64'(NSEND));

        // 5: reset after 10 shifts, then a full reload
        start_load();
        send_stream(2, -1, 1'b0);
        w = 0;
        while (n_shift < 10 && w < 100) begin
            tick();
            w++;
        end
        check("t5_ten_shifts", 64'(n_shift), 64'd10);
        reset_n = 1'b0;
        #1;
        check("t5_outputs_in_reset", 64'({word_ready, cfg_en, cfg_out, busy, done, error}), 64'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        start_load();
        send_stream(NSEND, NSEND - 1, 1'b0);
        wait_idle("t5_idle");
        check("t5_shifts",     64'(n_shift), 64'd37);
        check("t5_chain",      chain, EXP_FULL);
        check("t5_done_count", 64'(n_done), 64'd1);
        check("t5_error",      64'(error), 64'd0);

`ifdef CFG_LOADER_CRC_EN
        // 6: CRC word with one bit flipped
        extra5 = crc_good ^ 8'h10;
        start_load();
        send_stream(NSEND, NSEND - 1, 1'b0);
        wait_idle("t6_idle");
        check("t6_shifts",     64'(n_shift), 64'd37);
        check("t6_chain",      chain, EXP_FULL);
        check("t6_error",      64'(error), 64'd1);
        check("t6_done_count", 64'(n_done), 64'd0);
        extra5 = crc_good;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
